// File: rtl/sprite_if.sv
// Sprite renderer bus: timing-generator inputs, sprite ROM port and pixel output.
// Master drives timing/position/ROM data; slave is the renderer.
interface sprite_if;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       video_on;
  logic       frame_tick;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic [2:0] bg_rgb;
  logic [7:0] pixel_addr;
  logic [2:0] image_index;
  logic [2:0] pixel_data;
  logic [2:0] rgb;

  modport master (
    output h_cnt, v_cnt, video_on, frame_tick, sprite_x, sprite_y, bg_rgb, pixel_data,
    input  pixel_addr, image_index, rgb
  );

  modport slave (
    input  h_cnt, v_cnt, video_on, frame_tick, sprite_x, sprite_y, bg_rgb, pixel_data,
    output pixel_addr, image_index, rgb
  );
endinterface

// File: rtl/sprite_renderer.sv
// Two-stage 16x16 animated sprite overlay on a VGA pixel stream.
// Optional SPRITE_TRANSPARENT_EN: ROM colour 3'b111 shows the background.
module sprite_renderer #(
  parameter int unsigned ANIM_FRAMES = 8,
  parameter int unsigned NUM_IMAGES  = 2
) (
  input logic      clk,
  input logic      rst,
  sprite_if.slave  bus
);

  logic [9:0]  pos_x, pos_y;
  logic [7:0]  anim_cnt;
  logic [2:0]  image_q;
  logic [7:0]  addr_q;
  logic        hit_d, video_on_d;
  logic [2:0]  rgb_q;

  logic [10:0] dx, dy;
  logic        hit;
  logic [7:0]  addr_d;
  logic [2:0]  rgb_d;

  // 11-bit compare so a box near column/line 1023 never wraps to 0.
  always_comb begin
    dx     = {1'b0, bus.h_cnt} - {1'b0, pos_x};
    dy     = {1'b0, bus.v_cnt} - {1'b0, pos_y};
    hit    = ({1'b0, bus.h_cnt} >= {1'b0, pos_x}) &&
             ({1'b0, bus.h_cnt} <  ({1'b0, pos_x} + 11'd16)) &&
             ({1'b0, bus.v_cnt} >= {1'b0, pos_y}) &&
             ({1'b0, bus.v_cnt} <  ({1'b0, pos_y} + 11'd16));
    addr_d = hit ? {dy[3:0], dx[3:0]} : 8'd0;
  end

  always_comb begin
    rgb_d = 3'b000;
    if (video_on_d) begin
      if (hit_d) begin
`ifdef SPRITE_TRANSPARENT_EN
        rgb_d = (bus.pixel_data == 3'b111) ? bus.bg_rgb : bus.pixel_data;
`else
        rgb_d = bus.pixel_data;
`endif
      end else begin
        rgb_d = bus.bg_rgb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= 8'd0;
      hit_d      <= 1'b0;
      video_on_d <= 1'b0;
      rgb_q      <= 3'b000;
    end else begin
      addr_q     <= addr_d;
      hit_d      <= hit;
      video_on_d <= bus.video_on;
      rgb_q      <= rgb_d;
    end
  end

  // Position and image only move on frame_tick, i.e. during vertical blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x    <= 10'd0;
      pos_y    <= 10'd0;
      anim_cnt <= 8'd0;
      image_q  <= 3'd0;
    end else if (bus.frame_tick) begin
      pos_x <= bus.sprite_x;
      pos_y <= bus.sprite_y;
      if (anim_cnt == 8'(ANIM_FRAMES - 1)) begin
        anim_cnt <= 8'd0;
        if (image_q == 3'(NUM_IMAGES - 1)) begin
          image_q <= 3'd0;
        end else begin
          image_q <= image_q + 3'd1;
        end
      end else begin
        anim_cnt <= anim_cnt + 8'd1;
      end
    end
  end

  assign bus.pixel_addr  = addr_q;
  assign bus.image_index = image_q;
  assign bus.rgb         = rgb_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Randomised and directed bench for sprite_renderer against a pixel-level reference model.
module tb_sprite_renderer;
  localparam int unsigned ANIM = 8;
  localparam int unsigned NIMG = 2;

  logic clk;
  logic rst;
  sprite_if bus ();

  sprite_renderer #(
    .ANIM_FRAMES (ANIM),
    .NUM_IMAGES  (NIMG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sprite ROM: either a constant or a simple pattern of address and image.
  bit       rom_mode;
  bit [2:0] rom_const;
  always_comb begin
    bus.pixel_data = rom_mode ? rom_const
                              : (bus.pixel_addr[2:0] ^ bus.pixel_addr[6:4] ^ bus.image_index);
  end

  function automatic int rom_val(input int img, input int addr);
    if (rom_mode) return int'(rom_const);
    return ((addr & 7) ^ ((addr >> 4) & 7) ^ img) & 7;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stimulus for the next cycle
  bit t_rst, t_ft, t_von;
  int t_h, t_v, t_sx, t_sy, t_bg;

  // Reference model state
  int m_px, m_py, m_anim, m_img;
  int p_von, p_hit, p_addr;
  int e_addr, e_rgb;

  task automatic cycle();
    int inbox, pd;
    @(negedge clk);
    rst            = t_rst;
    bus.frame_tick = t_ft;
    bus.video_on   = t_von;
    bus.h_cnt      = 10'(t_h);
    bus.v_cnt      = 10'(t_v);
    bus.sprite_x   = 10'(t_sx);
    bus.sprite_y   = 10'(t_sy);
    bus.bg_rgb     = 3'(t_bg);
    if (t_rst) begin
      e_addr = 0; e_rgb = 0;
      p_von = 0; p_hit = 0; p_addr = 0;
      m_px = 0; m_py = 0; m_anim = 0; m_img = 0;
    end else begin
      if (p_von == 0) e_rgb = 0;
      else if (p_hit != 0) begin
        pd = rom_val(m_img, p_addr);
        e_rgb = pd;
`ifdef SPRITE_TRANSPARENT_EN
        if (pd == 7) e_rgb = t_bg;
`endif
      end else e_rgb = t_bg;
      inbox = (t_h >= m_px && t_h < m_px + 16 && t_v >= m_py && t_v < m_py + 16) ? 1 : 0;
      e_addr = inbox ? (t_v - m_py) * 16 + (t_h - m_px) : 0;
      p_von = int'(t_von); p_hit = inbox; p_addr = e_addr;
      if (t_ft) begin
        m_px = t_sx; m_py = t_sy;
        if (m_anim == ANIM - 1) begin
          m_anim = 0;
          m_img  = (m_img + 1) % NIMG;
        end else m_anim++;
      end
    end
    @(posedge clk);
    #1;
    chk("pixel_addr", int'(bus.pixel_addr), e_addr);
    chk("rgb", int'(bus.rgb), e_rgb);
    chk("image_index", int'(bus.image_index), m_img);
  endtask

  task automatic idle();
    t_rst = 0; t_ft = 0; t_von = 0; t_h = 0; t_v = 0;
  endtask

  initial begin
    rom_mode = 1; rom_const = 3'd0;
    t_sx = 0; t_sy = 0; t_bg = 5;
    idle();
    t_rst = 1;
    repeat (3) cycle();
    chk("reset_rgb", int'(bus.rgb), 0);
    chk("reset_addr", int'(bus.pixel_addr), 0);
    chk("reset_img", int'(bus.image_index), 0);

    // Latch position, then address a pixel inside the box
    idle(); t_ft = 1; t_sx = 100; t_sy = 50; cycle();
    idle(); t_von = 1; t_h = 106; t_v = 51; cycle();
    chk("pos_addr_22", int'(bus.pixel_addr), 22);
    idle(); cycle();
    chk("pos_rgb_rom0", int'(bus.rgb), 0);

    // Outside the box on either side, then blanking
    t_bg = 2;
    idle(); t_von = 1; t_h = 99;  t_v = 55; cycle();
    chk("left_addr", int'(bus.pixel_addr), 0);
    idle(); t_von = 1; t_h = 116; t_v = 55; cycle();
    chk("left_rgb_bg", int'(bus.rgb), 2);
    chk("right_addr", int'(bus.pixel_addr), 0);
    idle(); t_h = 106; t_v = 51; cycle();
    chk("right_rgb_bg", int'(bus.rgb), 2);
    idle(); cycle();
    chk("blank_rgb", int'(bus.rgb), 0);

    // Position change without frame_tick must not move the box
    t_sx = 200;
    idle(); t_von = 1; t_h = 106; t_v = 51; cycle();
    chk("no_tear_addr", int'(bus.pixel_addr), 22);
    idle(); t_von = 1; t_h = 206; t_v = 51; cycle();
    chk("no_tear_new_col", int'(bus.pixel_addr), 0);

    // Right-edge clipping, no wrap to column 0
    idle(); t_ft = 1; t_sx = 1020; t_sy = 0; cycle();
    idle(); t_von = 1; t_h = 3; t_v = 5; cycle();
    chk("clip_no_wrap", int'(bus.pixel_addr), 0);
    idle(); t_ft = 1; t_sx = 630; t_sy = 0; cycle();
    idle(); t_von = 1; t_h = 639; t_v = 5; cycle();
    chk("clip_col9", int'(bus.pixel_addr) & 15, 9);

    // ROM white inside the box
    rom_const = 3'd7; t_bg = 1;
    idle(); t_von = 1; t_h = 635; t_v = 3; cycle();
    idle(); cycle();
`ifdef SPRITE_TRANSPARENT_EN
    chk("transparent", int'(bus.rgb), 1);
`else
    chk("white_opaque", int'(bus.rgb), 7);
`endif

    // Animation stepping
    idle(); t_rst = 1; cycle();
    for (int i = 1; i <= 16; i++) begin
      idle(); t_ft = 1; cycle();
      if (i == 7)  chk("anim_before_8", int'(bus.image_index), 0);
      if (i == 8)  chk("anim_8th", int'(bus.image_index), 1);
      if (i == 16) chk("anim_16th", int'(bus.image_index), 0);
      idle(); cycle();
    end
    for (int i = 0; i < 7; i++) begin
      idle(); t_ft = 1; cycle();
    end
    idle(); t_rst = 1; t_ft = 1; cycle();
    chk("rst_over_tick", int'(bus.image_index), 0);
    idle(); t_ft = 1; cycle();
    chk("anim_cnt_cleared", int'(bus.image_index), 0);

    // Randomised traffic with the pattern ROM
    rom_mode = 0;
    for (int i = 0; i < 4000; i++) begin
      t_rst = ($urandom_range(0, 299) == 0);
      t_ft  = ($urandom_range(0, 15) == 0);
      t_von = ($urandom_range(0, 4) != 0);
      if (t_ft) begin
        t_sx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023))
                                           : int'($urandom_range(0, 1023));
        t_sy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023))
                                           : int'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 1) == 0) begin
        t_h = (m_px + int'($urandom_range(0, 24)) - 4) & 1023;
        t_v = (m_py + int'($urandom_range(0, 24)) - 4) & 1023;
      end else begin
        t_h = int'($urandom_range(0, 1023));
        t_v = int'($urandom_range(0, 1023));
      end
      t_bg = int'($urandom_range(0, 7));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
